run_length_detector: RTL and testbench

Serial run detector for a single-bit sample stream. It tracks the length and polarity of the current run of identical valid samples, and flags when that run reaches a runtime-programmable threshold. Detection can be restricted by polarity mode, and detection events are counted. It is the parametrised successor of the fixed 4-sample all-0/all-1 detector, and sits directly behind serial line samplers.

---
 rtl/run_det_pkg.sv | 32 +++
 rtl/sat_counter.sv | 42 ++++
 rtl/run_length_detector.sv | 119 +++++++++++
 tb/tb_run_length_detector.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared definitions for the run-length detector.
// Mode encodings, FSM states and the polarity filter.
package run_det_pkg;

    localparam logic [1:0] MODE_BOTH  = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ZEROS = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // True when a run of polarity val may raise a detection.
    function automatic logic mode_allows(
        input logic       val,
        input logic [1:0] mode
    );
        logic ok;
        ok = 1'b0;
        unique case (mode)
            MODE_BOTH:  ok = 1'b1;
            MODE_ONES:  ok = val;
            MODE_ZEROS: ok = ~val;
            MODE_OFF:   ok = 1'b0;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: clr, then load1, then inc.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, restart at one, or step without wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load1) begin
            count_d = W'(1);
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_length_detector.sv
// Run-length detector for a serial bit stream.
// Tracks run length/polarity and flags runs reaching a threshold.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int RUN_W = 4,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             w,
    input  logic [RUN_W-1:0] thresh,
    input  logic [1:0]       mode,
    output logic             s,
    output logic             s_pulse,
    output logic [RUN_W-1:0] run_len,
    output logic             run_val,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam logic [RUN_W-1:0] LEN_MAX = '1;

    state_e           state_q;
    state_e           state_d;
    logic             run_val_q;
    logic             run_val_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             len_clr;
    logic             len_load;
    logic             len_inc;
    logic             evt_clr;
    logic             evt_inc;
    logic             restart;
    logic [RUN_W-1:0] thr;
    logic [RUN_W-1:0] len_next;

    // A zero threshold would never be reached by a non-empty run.
    assign thr = (thresh == '0) ? RUN_W'(1) : thresh;

    // Next state, run tracking controls and pulse qualification.
    always_comb begin
        state_d   = state_q;
        run_val_d = run_val_q;
        pulse_d   = 1'b0;
        len_clr   = 1'b0;
        len_load  = 1'b0;
        len_inc   = 1'b0;
        evt_clr   = 1'b0;
        evt_inc   = 1'b0;
        restart   = (state_q == ST_EMPTY) || (w != run_val_q);
        len_next  = '0;
        if (clr) begin
            state_d   = ST_EMPTY;
            run_val_d = 1'b0;
            len_clr   = 1'b1;
            evt_clr   = 1'b1;
        end else if (in_valid) begin
            state_d = ST_RUN;
            if (restart) begin
                run_val_d = w;
                len_load  = 1'b1;
                len_next  = RUN_W'(1);
            end else begin
                len_inc  = 1'b1;
                len_next = (run_len == LEN_MAX) ? run_len
                         : run_len + RUN_W'(1);
            end
            pulse_d = (len_next == thr)
                    && (restart || (run_len < thr))
                    && mode_allows(w, mode);
            evt_inc = pulse_d;
        end
    end

    // State, polarity and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            run_val_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_val_q <= run_val_d;
            pulse_q   <= pulse_d;
        end
    end

    sat_counter #(
        .W(RUN_W)
    ) u_len (
        .clk   (clk),
        .reset (reset),
        .clr   (len_clr),
        .load1 (len_load),
        .inc   (len_inc),
        .count (run_len)
    );

    sat_counter #(
        .W(EVT_W)
    ) u_evt (
        .clk   (clk),
        .reset (reset),
        .clr   (evt_clr),
        .load1 (1'b0),
        .inc   (evt_inc),
        .count (evt_cnt)
    );

    assign s       = (state_q == ST_RUN)
                   && (run_len >= thr)
                   && mode_allows(run_val_q, mode);
    assign s_pulse = pulse_q;
    assign run_val = run_val_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector.
// Expected outputs are queued as stimulus is applied, popped on sampling.
module tb_run_length_detector;

    typedef struct packed {
        logic       s;
        logic       p;
        logic [3:0] len;
        logic       rv;
        logic [7:0] evt;
        logic [8:0] o2;
    } exp_t;

    typedef struct packed {
        logic       tick;
        logic       c;
        logic       v;
        logic       w;
        logic [1:0] mode;
        logic [3:0] thr;
        exp_t       e;
    } row_t;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic       w;
    logic [3:0] thresh;
    logic [1:0] mode;
    logic       s;
    logic       s_pulse;
    logic [3:0] run_len;
    logic       run_val;
    logic [7:0] evt_cnt;
    logic       s2;
    logic       p2;
    logic [3:0] len2;
    logic       rv2;
    logic [1:0] evt2;

    exp_t sb[$];
    exp_t got;
    exp_t want;
    int   checks;
    int   passed;

    run_length_detector #(.RUN_W(4), .EVT_W(8)) u_dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
        .w(w), .thresh(thresh), .mode(mode), .s(s),
        .s_pulse(s_pulse), .run_len(run_len), .run_val(run_val),
        .evt_cnt(evt_cnt)
    );

    run_length_detector #(.RUN_W(4), .EVT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
        .w(w), .thresh(thresh), .mode(mode), .s(s2),
        .s_pulse(p2), .run_len(len2), .run_val(rv2),
        .evt_cnt(evt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic s_, input logic p_,
                                input int len_, input logic rv_,
                                input int evt_);
        exp_t e;
        e.s   = s_;
        e.p   = p_;
        e.len = 4'(len_);
        e.rv  = rv_;
        e.evt = 8'(evt_);
        e.o2  = {s_, p_, 4'(len_), rv_, 2'((evt_ > 3) ? 3 : evt_)};
        return e;
    endfunction

    function automatic row_t r(input logic tick, input logic c,
                               input logic v, input logic w_,
                               input logic [1:0] m, input logic [3:0] th,
                               input exp_t e);
        row_t x;
        x.tick = tick;
        x.c    = c;
        x.v    = v;
        x.w    = w_;
        x.mode = m;
        x.thr  = th;
        x.e    = e;
        return x;
    endfunction

    function automatic exp_t sample();
        return {s, s_pulse, run_len, run_val, evt_cnt,
                s2, p2, len2, rv2, evt2};
    endfunction

    // Apply one row at the falling edge, queue its expectation,
    // then sample after the next rising edge (or at once if no tick).
    task automatic drive_row(input row_t rw);
        @(negedge clk);
        clr      = rw.c;
        in_valid = rw.v;
        w        = rw.w;
        mode     = rw.mode;
        thresh   = rw.thr;
        sb.push_back(rw.e);
        if (rw.tick) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; w = 1'b0;
        thresh = 4'd4; mode = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        sb.push_back(ex(0, 0, 0, 0, 0));
        got = sample();
        want = sb.pop_front();
        checks++;
        if (got !== want)
            $display("FAIL reset_hold got %h want %h", got, want);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(ex(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        got = sample();
        want = sb.pop_front();
        checks++;
        if (got !== want)
            $display("FAIL reset_release got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_legacy();
        row_t t[$];
        t.push_back(r(1, 0, 1, 1, 2'b00, 4, ex(0, 0, 1, 1, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 4, ex(0, 0, 2, 1, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 4, ex(0, 0, 3, 1, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 4, ex(1, 1, 4, 1, 1)));
        t.push_back(r(1, 0, 0, 0, 2'b00, 4, ex(1, 0, 4, 1, 1)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 4, ex(0, 0, 1, 0, 1)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 4, ex(0, 0, 2, 0, 1)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 4, ex(0, 0, 3, 0, 1)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 4, ex(1, 1, 4, 0, 2)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 4, ex(1, 0, 5, 0, 2)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL legacy[%0d] got %h want %h", i, got, want);
            else passed++;
        end
    endtask

    task automatic test_polarity();
        row_t t[$];
        t.push_back(r(1, 1, 0, 0, 2'b01, 3, ex(0, 0, 0, 0, 0)));
        t.push_back(r(1, 0, 1, 0, 2'b01, 3, ex(0, 0, 1, 0, 0)));
        t.push_back(r(1, 0, 1, 0, 2'b01, 3, ex(0, 0, 2, 0, 0)));
        t.push_back(r(1, 0, 1, 0, 2'b01, 3, ex(0, 0, 3, 0, 0)));
        t.push_back(r(0, 0, 0, 0, 2'b00, 3, ex(1, 0, 3, 0, 0)));
        t.push_back(r(0, 0, 0, 0, 2'b11, 3, ex(0, 0, 3, 0, 0)));
        t.push_back(r(0, 0, 0, 0, 2'b10, 3, ex(1, 0, 3, 0, 0)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 3, ex(1, 0, 4, 0, 0)));
        t.push_back(r(0, 0, 0, 0, 2'b00, 5, ex(0, 0, 4, 0, 0)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL polarity[%0d] got %h want %h", i, got, want);
            else passed++;
        end
    endtask

    task automatic test_gap_thr0();
        row_t t[$];
        t.push_back(r(1, 1, 0, 0, 2'b00, 0, ex(0, 0, 0, 0, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 0, ex(1, 1, 1, 1, 1)));
        for (int k = 0; k < 5; k++)
            t.push_back(r(1, 0, 0, 0, 2'b00, 0, ex(1, 0, 1, 1, 1)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 0, ex(1, 0, 2, 1, 1)));
        t.push_back(r(1, 0, 1, 0, 2'b00, 0, ex(1, 1, 1, 0, 2)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL gap_thr0[%0d] got %h want %h", i, got, want);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        row_t t[$];
        int   len;
        t.push_back(r(1, 1, 0, 0, 2'b00, 15, ex(0, 0, 0, 0, 0)));
        for (int k = 0; k < 20; k++) begin
            len = (k + 1 > 15) ? 15 : k + 1;
            t.push_back(r(1, 0, 1, 1, 2'b00, 15,
                          ex(len == 15, k == 14, len, 1, (k >= 14) ? 1 : 0)));
        end
        t.push_back(r(1, 1, 0, 0, 2'b00, 1, ex(0, 0, 0, 0, 0)));
        for (int k = 0; k < 5; k++)
            t.push_back(r(1, 0, 1, k[0], 2'b00, 1, ex(1, 1, 1, k[0], k + 1)));
        t.push_back(r(1, 0, 0, 0, 2'b00, 1, ex(1, 0, 1, 0, 5)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL saturation[%0d] got %h want %h", i, got, want);
            else passed++;
        end
    endtask

    task automatic test_clr_collision();
        row_t t[$];
        t.push_back(r(1, 1, 0, 0, 2'b00, 2, ex(0, 0, 0, 0, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 2, ex(0, 0, 1, 1, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 2, ex(1, 1, 2, 1, 1)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 2, ex(1, 0, 3, 1, 1)));
        t.push_back(r(1, 1, 1, 1, 2'b00, 2, ex(0, 0, 0, 0, 0)));
        t.push_back(r(1, 0, 1, 1, 2'b00, 2, ex(0, 0, 1, 1, 0)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL clr_collision[%0d] got %h want %h",
                         i, got, want);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        row_t t[$];
        t.push_back(r(1, 1, 0, 0, 2'b00, 4, ex(0, 0, 0, 0, 0)));
        for (int k = 0; k < 7; k++)
            t.push_back(r(1, 0, 1, 1, 2'b00, 4,
                          ex(k >= 3, k == 3, k + 1, 1, (k >= 3) ? 1 : 0)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL async_run[%0d] got %h want %h", i, got, want);
            else passed++;
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        sb.push_back(ex(0, 0, 0, 0, 0));
        #1;
        got = sample();
        want = sb.pop_front();
        checks++;
        if (got !== want)
            $display("FAIL async_reset got %h want %h", got, want);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        t.delete();
        t.push_back(r(1, 0, 1, 1, 2'b00, 4, ex(0, 0, 1, 1, 0)));
        foreach (t[i]) begin
            drive_row(t[i]);
            got = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL async_restart[%0d] got %h want %h",
                         i, got, want);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_legacy();
        test_polarity();
        test_gap_thr0();
        test_saturation();
        test_clr_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
